// File: rtl/axis_frame_bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_bram_writer
// Brief    : AXI-Stream slave that writes one fixed-length D2Q9 lattice frame
//            (nine 16-bit lanes per beat, one cell per beat) into the nine
//            per-direction cell RAMs at sequential addresses. It flags framing
//            (tlast) errors and byte-strobe errors in sticky status bits.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_bram_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    // 2**ADDRESS_WIDTH must be >= DEPTH so the full frame fits in the RAMs
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                         s00_axis_aclk,
    input  logic                         s00_axis_aresetn,
    input  logic                         frame_accept,
    input  logic                         s00_axis_tvalid,
    output logic                         s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]      s00_axis_tdata,
    input  logic [9*DATA_WIDTH/8-1:0]    s00_axis_tstrb,
    input  logic                         s00_axis_tlast,
    output logic                         wr_en,
    output logic [ADDRESS_WIDTH-1:0]     wr_addr,
    output logic [9*DATA_WIDTH-1:0]      wr_data,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         tlast_err,
    output logic                         strb_err
);

    localparam int                       c_TDATA_W   = 9 * DATA_WIDTH;
    localparam int                       c_TSTRB_W   = c_TDATA_W / 8;
    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [c_TSTRB_W-1:0]     c_STRB_ALL  = {c_TSTRB_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [c_TDATA_W-1:0]     wr_data_q, wr_data_d;
    logic                     tlast_err_q, tlast_err_d;
    logic                     strb_err_q, strb_err_d;

    logic w_in_recv;
    logic w_handshake;
    logic w_cnt_last;

    // Ready depends only on the state register, so tready has no path from tvalid.
    assign w_in_recv   = (state_q == S_RECV);
    assign w_handshake = w_in_recv & s00_axis_tvalid;
    assign w_cnt_last  = (cnt_q == c_LAST_ADDR);

    assign s00_axis_tready = w_in_recv;
    assign busy            = w_in_recv;
    // DONE lasts exactly one cycle and follows the terminating beat, so the
    // pulse lines up with the final registered write.
    assign frame_done      = (state_q == S_DONE);
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign tlast_err       = tlast_err_q;
    assign strb_err        = strb_err_q;

    // Next-state, beat counter, write-port capture and sticky error logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        tlast_err_d = tlast_err_q;
        strb_err_d  = strb_err_q;

        case (state_q)
            S_IDLE: begin
                if (frame_accept) begin
                    state_d     = S_RECV;
                    cnt_d       = '0;
                    tlast_err_d = 1'b0;
                    strb_err_d  = 1'b0;
                end
            end

            S_RECV: begin
                if (w_handshake) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = s00_axis_tdata;
                    cnt_d     = cnt_q + ADDRESS_WIDTH'(1);
                    // A frame ends on tlast or on the last cell, whichever
                    // comes first; the write count never exceeds DEPTH.
                    if (s00_axis_tlast || w_cnt_last) begin
                        state_d = S_DONE;
                    end
                    if (s00_axis_tlast != w_cnt_last) begin
                        tlast_err_d = 1'b1;
                    end
                    if (s00_axis_tstrb != c_STRB_ALL) begin
                        strb_err_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            tlast_err_q <= 1'b0;
            strb_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            tlast_err_q <= tlast_err_d;
            strb_err_q  <= strb_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_bram_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_frame_bram_writer
// Brief    : Self-checking bench for axis_frame_bram_writer. A frame-level
//            reference (beat table plus frame-termination rules) predicts the
//            RAM writes, frame_done pulses and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_bram_writer;

    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;
    localparam int TW    = 9 * DW;
    localparam int SW    = TW / 8;
    localparam int NBEAT = DEPTH + 8;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b1;
    logic          frame_accept = 1'b0;
    logic          tvalid       = 1'b0;
    logic          tlast        = 1'b0;
    logic [TW-1:0] tdata        = '0;
    logic [SW-1:0] tstrb        = '1;
    logic          tready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic          tlast_err;
    logic          strb_err;

    int errors = 0;
    int checks = 0;

    logic [TW-1:0] beats [0:NBEAT-1];
    logic [AW-1:0] log_addr [$];
    logic [TW-1:0] log_data [$];
    int            done_total      = 0;
    int            done_without_wr = 0;
    int            strobe_mismatch = 0;
    logic          hs_seen         = 1'b0;

    axis_frame_bram_writer #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .frame_accept     (frame_accept),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tready  (tready),
        .s00_axis_tdata   (tdata),
        .s00_axis_tstrb   (tstrb),
        .s00_axis_tlast   (tlast),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .busy             (busy),
        .frame_done       (frame_done),
        .tlast_err        (tlast_err),
        .strb_err         (strb_err)
    );

    always #5 clk = ~clk;

    // RAM-side monitor: logs every write, counts frame_done pulses and
    // checks that wr_en follows exactly the handshakes of the prior cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en !== hs_seen) strobe_mismatch++;
            if (wr_en === 1'b1) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
            end
            if (frame_done === 1'b1) begin
                done_total++;
                if (wr_en !== 1'b1) done_without_wr++;
            end
            hs_seen = tvalid && tready;
        end else begin
            hs_seen = 1'b0;
        end
    end

    task automatic gen_beats(input bit pattern);
        for (int i = 0; i < NBEAT; i++) begin
            for (int k = 0; k < 9; k++) begin
                if (pattern) beats[i][16*k +: 16] = 16'(i*9 + k);
                else         beats[i][16*k +: 16] = 16'($urandom);
            end
        end
    endtask

    // Arms one frame, streams beats with the given tvalid duty, and checks the
    // resulting writes against the frame rules. abort_at >= 0 resets the DUT
    // once that many beats have been accepted.
    task automatic run_frame(input string name, input int tlast_pos,
                             input int strb_pos, input int duty, input int abort_at);
        int start, idx, cyc, n_exp, done0, nwr, bad_a, bad_d, extra_bad, lim;
        bit hs, done, exp_tlast_err, exp_strb_err;

        n_exp = (tlast_pos >= 0 && tlast_pos < DEPTH) ? tlast_pos + 1 : DEPTH;
        if (abort_at >= 0) n_exp = abort_at;
        exp_tlast_err = (tlast_pos != DEPTH - 1);
        exp_strb_err  = (strb_pos >= 0 && strb_pos < n_exp);

        start = log_addr.size();
        done0 = done_total;

        frame_accept = 1'b1;
        @(posedge clk); #1;
        frame_accept = 1'b0;
        checks++;
        if ({busy, tready, tlast_err, strb_err} !== 4'b1100)
            $display("FAIL %s arm: busy/tready/tlast_err/strb_err=%b required 1100",
                     name, {busy, tready, tlast_err, strb_err});

        idx = 0; cyc = 0; done = 0;
        while (!done && cyc < 4*DEPTH + 100) begin
            if (abort_at >= 0 && idx == abort_at) break;
            lim    = (idx < NBEAT) ? idx : NBEAT - 1;
            tvalid = ($urandom_range(99) < duty);
            tdata  = beats[lim];
            tlast  = (idx == tlast_pos);
            tstrb  = (idx == strb_pos) ? 18'h3FFFE : 18'h3FFFF;
            hs     = tvalid && tready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                if (idx == strb_pos) begin
                    checks++;
                    if (strb_err !== 1'b1) begin
                        errors++;
                        $display("FAIL %s strb_err_timing: got %b required 1", name, strb_err);
                    end
                end
                idx++;
            end
            if (frame_done === 1'b1) done = 1;
        end
        tlast = 1'b0;
        tstrb = '1;

        if (abort_at >= 0) begin
            @(negedge clk); #1;
            rst_n = 1'b0;
            tvalid = 1'b0;
            #1;
            checks++;
            if ({tready, wr_en, busy, frame_done, tlast_err, strb_err, wr_addr, wr_data} !== '0) begin
                errors++;
                $display("FAIL %s reset_outputs: wr_en=%b busy=%b wr_addr=%0d required all zero",
                         name, wr_en, busy, wr_addr);
            end
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (done_total != done0) begin
                errors++;
                $display("FAIL %s no_frame_done: got %0d pulses required 0", name, done_total - done0);
            end
        end else begin
            tvalid = 1'b0;
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL %s timeout: no frame_done after %0d cycles", name, cyc);
            end
            checks++;
            if ({tready, busy} !== 2'b00) begin
                errors++;
                $display("FAIL %s done_ready: tready/busy=%b required 00", name, {tready, busy});
            end
            if (duty >= 100) begin
                checks++;
                if (cyc != n_exp) begin
                    errors++;
                    $display("FAIL %s throughput: got %0d cycles required %0d", name, cyc, n_exp);
                end
            end
            // Further beats after the frame ends must be refused.
            extra_bad = 0;
            tvalid = 1'b1;
            tdata  = beats[NBEAT-1];
            for (int r = 0; r < 4; r++) begin
                @(posedge clk); #1;
                if (tready !== 1'b0) extra_bad++;
                if (r == 0 && frame_done !== 1'b0) extra_bad++;
            end
            tvalid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (extra_bad != 0) begin
                errors++;
                $display("FAIL %s post_frame: %0d ready/pulse violations required 0", name, extra_bad);
            end
            checks++;
            if (done_total - done0 != 1) begin
                errors++;
                $display("FAIL %s frame_done_count: got %0d required 1", name, done_total - done0);
            end
            checks++;
            if (tlast_err !== exp_tlast_err || strb_err !== exp_strb_err) begin
                errors++;
                $display("FAIL %s error_flags: tlast_err=%b strb_err=%b required %b %b",
                         name, tlast_err, strb_err, exp_tlast_err, exp_strb_err);
            end
        end

        nwr = log_addr.size() - start;
        checks++;
        if (nwr != n_exp) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, nwr, n_exp);
        end
        bad_a = 0; bad_d = 0;
        for (int i = 0; i < nwr && i < n_exp; i++) begin
            if (log_addr[start+i] !== AW'(i))     bad_a++;
            if (log_data[start+i] !== beats[i])   bad_d++;
        end
        checks++;
        if (bad_a != 0 || bad_d != 0) begin
            errors++;
            $display("FAIL %s contents: %0d bad addresses, %0d bad data words required 0",
                     name, bad_a, bad_d);
        end
        checks++;
        if (strobe_mismatch != 0 || done_without_wr != 0) begin
            errors++;
            $display("FAIL %s wr_en_timing: %0d strobe mismatches, %0d lone frame_done required 0",
                     name, strobe_mismatch, done_without_wr);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tready, wr_en, busy, frame_done, tlast_err, strb_err, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_assert: outputs not all zero (wr_en=%b busy=%b)", wr_en, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({tready, wr_en, busy, frame_done, tlast_err, strb_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle: flags=%b required 000000",
                     {tready, wr_en, busy, frame_done, tlast_err, strb_err});
        end
    endtask

    task automatic test_nominal();
        int s;
        logic [TW-1:0] w;
        gen_beats(1'b1);
        s = log_data.size();
        run_frame("nominal", DEPTH-1, -1, 100, -1);
        checks++;
        if (log_data.size() <= s + 1234) begin
            errors++;
            $display("FAIL nominal ram5_1234: only %0d writes logged", log_data.size() - s);
        end else begin
            w = log_data[s+1234];
            if (w[16*5 +: 16] !== 16'(1234*9 + 5)) begin
                errors++;
                $display("FAIL nominal ram5_1234: got %0d required %0d", w[16*5 +: 16], 1234*9 + 5);
            end
        end
    endtask

    task automatic test_backpressure();
        gen_beats(1'b0);
        run_frame("backpressure", DEPTH-1, -1, 50, -1);
    endtask

    task automatic test_early_tlast();
        gen_beats(1'b0);
        run_frame("early_tlast", 99, -1, 100, -1);
    endtask

    task automatic test_missing_tlast();
        gen_beats(1'b0);
        run_frame("missing_tlast", -1, -1, 100, -1);
    endtask

    task automatic test_strobe();
        gen_beats(1'b0);
        run_frame("strobe", DEPTH-1, 10, 80, -1);
    endtask

    task automatic test_reset_midframe();
        gen_beats(1'b0);
        run_frame("reset_mid", DEPTH-1, -1, 100, 700);
        gen_beats(1'b0);
        run_frame("after_reset", DEPTH-1, -1, 70, -1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_tlast();
        test_missing_tlast();
        test_strobe();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_frame_bram_writer.md
# axis_frame_bram_writer

AXI-Stream slave that receives one lattice frame of D2Q9 distribution data as 144-bit beats and writes it into the nine per-direction cell RAMs at sequential addresses. It is the receive-side counterpart of the BRAM-to-stream frame reader: host/DMA stream in, RAM write port out. Frame length is fixed at DEPTH beats, one cell per beat. Framing and strobe errors are flagged, not silently absorbed.

## Interface
- DATA_WIDTH, 16, width of one distribution value (lane)
- DEPTH, 2500, cells per frame = beats per frame
- ADDRESS_WIDTH, 12, RAM address width; must satisfy 2^ADDRESS_WIDTH >= DEPTH

- s00_axis_aclk  in  1  single clock for all logic
- s00_axis_aresetn  in  1  reset, asynchronous, active-low
- frame_accept  in  1  level; arms reception of one frame when sampled high in IDLE
- s00_axis_tvalid  in  1  beat valid
- s00_axis_tready  out  1  beat ready
- s00_axis_tdata  in  144  nine lanes; lane k = tdata[16k+15:16k], k: 0=rest(null),1=n,2=ne,3=e,4=se,5=s,6=sw,7=w,8=nw
- s00_axis_tstrb  in  18  byte strobes
- s00_axis_tlast  in  1  last beat of frame
- wr_en  out  1  write strobe, common to all nine RAMs
- wr_addr  out  ADDRESS_WIDTH  cell address
- wr_data  out  144  registered tdata; lane k drives RAM k data_in
- busy  out  1  high in RECV
- frame_done  out  1  one-cycle pulse at frame end
- tlast_err  out  1  sticky; tlast mismatch in current/last frame
- strb_err  out  1  sticky; accepted beat had any tstrb bit 0

## Operation
- States: IDLE, RECV, DONE (state register).
- IDLE: tready=0. frame_accept=1 -> RECV; on this transition beat counter cnt=0, tlast_err=0, strb_err=0.
- RECV: tready=1. Each handshake (tvalid&tready) registers wr_en=1, wr_addr=cnt, wr_data=tdata; cnt<=cnt+1. No handshake -> wr_en=0, wr_addr/wr_data hold.
- Expected last beat: cnt==DEPTH-1.
  - tlast=1 and cnt==DEPTH-1: normal end -> DONE.
  - tlast=1 and cnt<DEPTH-1: early end; beat written, tlast_err<=1, -> DONE. Remaining addresses untouched.
  - tlast=0 and cnt==DEPTH-1: beat written, tlast_err<=1, -> DONE (frame never exceeds DEPTH writes; addresses never wrap).
- Any accepted beat with tstrb!=18'h3FFFF: data written as-is, strb_err<=1.
- DONE: tready=0, frame_done=1 for exactly one cycle, -> IDLE unconditionally. frame_accept held high re-arms in the following IDLE cycle (min 2 idle-ready cycles between frames).
- tvalid while tready=0 is ignored; no data captured.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0; tready, wr_en, busy, frame_done, tlast_err, strb_err = 0; wr_addr=0, wr_data=0.
- tready and busy are decoded from the state register only (no combinational path from tvalid/tdata).
- Handshake in cycle t -> wr_en/wr_addr/wr_data valid in cycle t+1 (latency 1).
- Terminating beat in cycle t -> state DONE in t+1: tready=0 in t+1 (no extra beat accepted), frame_done=1 in t+1 coincident with the final wr_en; IDLE in t+2.
- Errors update in the cycle after the offending handshake; stay set through DONE/IDLE until the next frame arms.
- Reset mid-frame: immediate return to IDLE, write strobe drops, partial frame abandoned, no frame_done.
- Throughput: one beat per cycle in RECV with tvalid held high; full frame = DEPTH cycles + 1 DONE cycle.

## Test plan
- Nominal: DEPTH=2500, frame_accept, 2500 beats back-to-back, lane k of beat i = 16'(i*9+k), tlast on beat 2499 -> 2500 writes, wr_addr 0..2499 in order, RAM5[1234]=16'(1234*9+5), frame_done one pulse with last write, no errors.
- Backpressure/gaps: tvalid random 50% duty -> same RAM contents, wr_en only the cycle after handshakes, wr_addr contiguous.
- Early tlast on beat 99 -> 100 writes (addr 0..99), tlast_err=1, frame_done pulses, next beats with tvalid=1 see tready=0 and are not written.
- Missing tlast: 2500 beats, tlast=0 throughout -> 2500 writes, tlast_err=1, frame_done pulses, beat 2501 not accepted; next armed frame clears tlast_err.
- Strobe: beat 10 with tstrb=18'h3FFFE -> beat written, strb_err=1 from following cycle, held until next frame arms.
- Reset at beat 700 -> all outputs 0 within the reset cycle, no frame_done; fresh frame afterwards writes from addr 0 correctly.
